complex_divider: RTL and testbench
==================================

COMPLEX_DIVIDER -- requirements
Module: complex_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning signed two's-complement width of every data input and output.
REQ-002 SHALL have parameter FIXED_POINT, default 11, meaning the number of fractional bits in all operands and results (1.0 = 2^FIXED_POINT).
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-004 SHALL have ports: clk, input, 1, clock (all logic rising-edge).
REQ-005 SHALL have ports: rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports: In_One_Re / In_One_Im, input, WIDTH signed, dividend a real / imaginary.
REQ-007 SHALL have ports: In_Two_Re / In_Two_Im, input, WIDTH signed, divisor b real / imaginary.
REQ-008 SHALL have ports: In_Valid, input, 1, operands valid.
REQ-009 SHALL have ports: In_Ready, output, 1, block can accept operands.
REQ-010 SHALL have ports: Out_Re / Out_Im, output, WIDTH signed, quotient a/b real / imaginary.
REQ-011 SHALL have ports: Out_Valid, output, 1, result valid.
REQ-012 SHALL have ports: Out_Ready, input, 1, consumer accepts result.
REQ-013 SHALL have ports: Div_Zero, output, 1, divisor was 0+j0.
REQ-014 SHALL have ports: Sat, output, 1, at least one quotient component saturated.

Function
REQ-015 SHALL compute a/b = a*conj(b)/|b|^2:
- num_re = ar*br + ai*bi
- num_im = ai*br - ar*bi
- den = br^2 + bi^2
- all terms full precision, 2*WIDTH+1 bits
REQ-016 SHALL compute each component as sign(num) * floor((|num| << FIXED_POINT) / den), i.e. truncation toward zero.
REQ-017 SHALL implement the FSM with states IDLE, CALC, DIV, DONE.
REQ-018 SHALL behave in IDLE as follows:
- In_Ready=1
- on In_Valid=1, capture all four inputs and go to CALC
REQ-019 SHALL behave in CALC as follows:
- one cycle
- register num_re, num_im, den and signs
- evaluate overflow: (|num| << FIXED_POINT) >= (den << WIDTH)
- evaluate den==0
- if den==0, go to DONE; else go to DIV
REQ-020 SHALL behave in DIV as follows:
- exactly WIDTH cycles of radix-2 restoring division
- one quotient magnitude bit per cycle, MSB first
- real and imaginary divided in parallel against the shared den
- iteration counter, then go to DONE
REQ-021 SHALL behave in DONE as follows:
- Out_Valid=1; Out_Re, Out_Im, Div_Zero and Sat stable
- on Out_Ready=1, go to IDLE
REQ-022 SHALL give a latency of WIDTH+2 cycles from the accepting edge to Out_Valid: the accept edge is cycle 0 and Out_Valid is first high after edge WIDTH+2.
REQ-023 SHALL hold In_Ready=0 in CALC, DIV and DONE, and SHALL ignore In_Valid in those states.
REQ-024 SHALL deassert In_Ready during the DONE->IDLE transfer cycle, so no same-cycle re-accept occurs; the next operands are accepted one cycle later.
REQ-025 SHALL saturate each component independently:
- positive overflow or magnitude > 2^(WIDTH-1)-1 gives 2^(WIDTH-1)-1
- negative overflow or magnitude > 2^(WIDTH-1) gives -2^(WIDTH-1)
- Sat=1 if either component saturates
REQ-026 SHALL force a zero result to 0 regardless of num sign, never -0 or an artefact.
REQ-027 SHALL, when den==0, set Out_Re=0, Out_Im=0, Div_Zero=1 and Sat=0.
REQ-028 SHALL hold Out_Re, Out_Im, Div_Zero and Sat unchanged while Out_Valid=1 and Out_Ready=0, for any number of cycles.
REQ-029 SHALL keep Out_Re, Out_Im, Div_Zero and Sat at their last values while Out_Valid=0; these outputs are only qualified by Out_Valid.

Reset
REQ-030 SHALL, on rst=1 at a clock edge:
- set state=IDLE
- set In_Ready=1 from the following cycle
- set Out_Valid=0, Out_Re=0, Out_Im=0, Div_Zero=0, Sat=0
- clear the iteration counter and all datapath registers
REQ-031 SHALL abort any in-flight operation on reset in any state, including mid-DIV and DONE awaiting Out_Ready; no result is produced for it.
REQ-032 SHALL give reset priority over In_Valid and Out_Ready in the same cycle.

Verification (WIDTH=16, FIXED_POINT=11, 1.0=2048)
REQ-033 SHALL cover identity: a=(2048,0), b=(2048,0) -> Out=(2048,0), Div_Zero=0, Sat=0, Out_Valid exactly 18 cycles after accept.
REQ-034 SHALL cover complex division and truncation:
- a=(2048,2048), b=(0,2048) -> Out=(2048,-2048)
- a=(2048,0), b=(6144,0) -> Out=(682,0)
- a=(-2048,0), b=(6144,0) -> Out=(-682,0)
REQ-035 SHALL cover divide by zero: a=(1024,-512), b=(0,0) -> Out=(0,0), Div_Zero=1, Sat=0, Out_Valid 2 cycles after accept.
REQ-036 SHALL cover saturation:
- a=(16384,-16384), b=(64,0) -> Out=(32767,-32768), Sat=1
- a=(2048,0), b=(2048,0) afterwards -> Sat=0
REQ-037 SHALL cover handshake:
- Out_Ready=0 for 5 cycles in DONE -> outputs and Out_Valid held
- In_Valid pulses during CALC/DIV -> ignored, In_Ready=0
- back-to-back operations -> second accepted one cycle after the Out_Ready handshake
REQ-038 SHALL cover reset mid-operation: rst=1 at DIV iteration 7 -> next cycle Out_Valid=0, all outputs 0, In_Ready=1; a new operation then completes with the correct result.

Source files
------------

// File: rtl/complex_divider.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : complex_divider
//  Purpose  : Fixed-point complex division q = a / b = a*conj(b) / |b|^2.
//             Each quotient component is truncated toward zero and saturated
//             to the signed WIDTH-bit range. A divisor of 0+j0 yields 0+j0
//             with Div_Zero set.
//  Ports    : clk, rst                    clock, synchronous active-high reset
//             In_One_Re/Im, In_Two_Re/Im  dividend a, divisor b (signed)
//             In_Valid / In_Ready         operand handshake
//             Out_Re/Out_Im               quotient (signed)
//             Out_Valid / Out_Ready       result handshake
//             Div_Zero, Sat               divide-by-zero, saturation flags
//  Revision : 1.0 - initial release
// ============================================================================
module complex_divider #(
    parameter int WIDTH       = 16,
    parameter int FIXED_POINT = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] In_One_Re,
    input  logic signed [WIDTH-1:0] In_One_Im,
    input  logic signed [WIDTH-1:0] In_Two_Re,
    input  logic signed [WIDTH-1:0] In_Two_Im,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    output logic signed [WIDTH-1:0] Out_Re,
    output logic signed [WIDTH-1:0] Out_Im,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic                    Div_Zero,
    output logic                    Sat
);

    // Full-precision product/sum width, and the extended width that holds
    // both |num| << FIXED_POINT and den << WIDTH without loss.
    localparam int PW = 2 * WIDTH + 1;
    localparam int EW = PW + WIDTH + FIXED_POINT;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0]    C_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              r_state;
    logic signed [WIDTH-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
    logic [EW-1:0]           r_rem_re, r_rem_im, r_dsh;
    logic [WIDTH-1:0]        r_q_re, r_q_im;
    logic                    r_neg_re, r_neg_im, r_ovf_re, r_ovf_im, r_dz;
    logic [CW-1:0]           r_cnt;
    logic [WIDTH-1:0]        r_out_re, r_out_im;
    logic                    r_out_valid, r_div_zero, r_sat;

    // ------------------------------------------------------------------
    // CALC-stage arithmetic on the captured operands
    // ------------------------------------------------------------------
    logic signed [2*WIDTH-1:0] w_p_rr, w_p_ii, w_p_ir, w_p_ri, w_p_bb_r, w_p_bb_i;
    logic signed [PW-1:0]      w_num_re, w_num_im;
    logic [PW-1:0]             w_den, w_mag_re, w_mag_im;
    logic [EW-1:0]             w_n_re, w_n_im, w_dlim, w_dinit;
    logic                      w_ovf_re, w_ovf_im;

    always_comb begin
        w_p_rr   = $signed({{WIDTH{r_a_re[WIDTH-1]}}, r_a_re}) * $signed({{WIDTH{r_b_re[WIDTH-1]}}, r_b_re});
        w_p_ii   = $signed({{WIDTH{r_a_im[WIDTH-1]}}, r_a_im}) * $signed({{WIDTH{r_b_im[WIDTH-1]}}, r_b_im});
        w_p_ir   = $signed({{WIDTH{r_a_im[WIDTH-1]}}, r_a_im}) * $signed({{WIDTH{r_b_re[WIDTH-1]}}, r_b_re});
        w_p_ri   = $signed({{WIDTH{r_a_re[WIDTH-1]}}, r_a_re}) * $signed({{WIDTH{r_b_im[WIDTH-1]}}, r_b_im});
        w_p_bb_r = $signed({{WIDTH{r_b_re[WIDTH-1]}}, r_b_re}) * $signed({{WIDTH{r_b_re[WIDTH-1]}}, r_b_re});
        w_p_bb_i = $signed({{WIDTH{r_b_im[WIDTH-1]}}, r_b_im}) * $signed({{WIDTH{r_b_im[WIDTH-1]}}, r_b_im});

        w_num_re = $signed({w_p_rr[2*WIDTH-1], w_p_rr} + {w_p_ii[2*WIDTH-1], w_p_ii});
        w_num_im = $signed({w_p_ir[2*WIDTH-1], w_p_ir} - {w_p_ri[2*WIDTH-1], w_p_ri});
        // Squares are never negative, so zero-extension is exact.
        w_den    = {1'b0, w_p_bb_r} + {1'b0, w_p_bb_i};

        w_mag_re = w_num_re[PW-1] ? PW'(-w_num_re) : PW'(w_num_re);
        w_mag_im = w_num_im[PW-1] ? PW'(-w_num_im) : PW'(w_num_im);

        w_n_re   = {{(EW-PW){1'b0}}, w_mag_re} << FIXED_POINT;
        w_n_im   = {{(EW-PW){1'b0}}, w_mag_im} << FIXED_POINT;
        w_dlim   = {{(EW-PW){1'b0}}, w_den} << WIDTH;
        w_dinit  = {{(EW-PW){1'b0}}, w_den} << (WIDTH - 1);

        // Quotient magnitude would need more than WIDTH bits.
        w_ovf_re = (w_n_re >= w_dlim);
        w_ovf_im = (w_n_im >= w_dlim);
    end

    // ------------------------------------------------------------------
    // Restoring division step: remainder vs. divisor shifted to bit k
    // ------------------------------------------------------------------
    logic w_ge_re, w_ge_im;

    always_comb begin
        w_ge_re = (r_rem_re >= r_dsh);
        w_ge_im = (r_rem_im >= r_dsh);
    end

    // ------------------------------------------------------------------
    // Final sign application and saturation
    // ------------------------------------------------------------------
    logic             w_sat_re, w_sat_im;
    logic [WIDTH-1:0] w_res_re, w_res_im;

    always_comb begin
        // A negative result may reach exactly -2^(WIDTH-1) without saturating.
        w_sat_re = r_ovf_re | (r_neg_re ? (r_q_re > C_MIN) : r_q_re[WIDTH-1]);
        w_sat_im = r_ovf_im | (r_neg_im ? (r_q_im > C_MIN) : r_q_im[WIDTH-1]);
        w_res_re = w_sat_re ? (r_neg_re ? C_MIN : C_MAX) : (r_neg_re ? -r_q_re : r_q_re);
        w_res_im = w_sat_im ? (r_neg_im ? C_MIN : C_MAX) : (r_neg_im ? -r_q_im : r_q_im);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a_re      <= '0;
            r_a_im      <= '0;
            r_b_re      <= '0;
            r_b_im      <= '0;
            r_rem_re    <= '0;
            r_rem_im    <= '0;
            r_dsh       <= '0;
            r_q_re      <= '0;
            r_q_im      <= '0;
            r_neg_re    <= 1'b0;
            r_neg_im    <= 1'b0;
            r_ovf_re    <= 1'b0;
            r_ovf_im    <= 1'b0;
            r_dz        <= 1'b0;
            r_cnt       <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_valid <= 1'b0;
            r_div_zero  <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (In_Valid) begin
                        r_a_re  <= In_One_Re;
                        r_a_im  <= In_One_Im;
                        r_b_re  <= In_Two_Re;
                        r_b_im  <= In_Two_Im;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem_re <= w_n_re;
                    r_rem_im <= w_n_im;
                    r_dsh    <= w_dinit;
                    r_neg_re <= w_num_re[PW-1];
                    r_neg_im <= w_num_im[PW-1];
                    r_ovf_re <= w_ovf_re;
                    r_ovf_im <= w_ovf_im;
                    r_dz     <= (w_den == '0);
                    r_q_re   <= '0;
                    r_q_im   <= '0;
                    r_cnt    <= '0;
                    r_state  <= (w_den == '0) ? S_DONE : S_DIV;
                end
                S_DIV: begin
                    if (w_ge_re) r_rem_re <= r_rem_re - r_dsh;
                    if (w_ge_im) r_rem_im <= r_rem_im - r_dsh;
                    r_q_re <= {r_q_re[WIDTH-2:0], w_ge_re};
                    r_q_im <= {r_q_im[WIDTH-2:0], w_ge_im};
                    r_dsh  <= r_dsh >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) r_state <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle registers the result; afterwards it is
                    // held until the consumer takes it.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_div_zero  <= r_dz;
                        r_out_re    <= r_dz ? '0 : w_res_re;
                        r_out_im    <= r_dz ? '0 : w_res_im;
                        r_sat       <= r_dz ? 1'b0 : (w_sat_re | w_sat_im);
                    end else if (Out_Ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign In_Ready  = (r_state == S_IDLE);
    assign Out_Re    = r_out_re;
    assign Out_Im    = r_out_im;
    assign Out_Valid = r_out_valid;
    assign Div_Zero  = r_div_zero;
    assign Sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_complex_divider.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : tb_complex_divider
//  Purpose  : Directed self-checking bench for complex_divider
//             (WIDTH=16, FIXED_POINT=11, 1.0 = 2048).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_complex_divider;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] in_one_re = '0, in_one_im = '0, in_two_re = '0, in_two_im = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] out_re, out_im;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               div_zero, sat;

    int total = 0;
    int bad   = 0;

    complex_divider #(.WIDTH(16), .FIXED_POINT(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .In_One_Re (in_one_re),
        .In_One_Im (in_one_im),
        .In_Two_Re (in_two_re),
        .In_Two_Im (in_two_im),
        .In_Valid  (in_valid),
        .In_Ready  (in_ready),
        .Out_Re    (out_re),
        .Out_Im    (out_im),
        .Out_Valid (out_valid),
        .Out_Ready (out_ready),
        .Div_Zero  (div_zero),
        .Sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, then wait (bounded) for Out_Valid.
    // lat counts edges after the accept edge; -1 means the bound expired.
    task automatic run_op(input logic signed [15:0] ar, ai, br, bi, output int lat);
        in_one_re = ar; in_one_im = ai; in_two_re = br; in_two_im = bi;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_re !== 16'sd0 || out_im !== 16'sd0) begin bad++; $display("FAIL reset_out: got (%0d,%0d) want (0,0)", out_re, out_im); end
        total++; if (div_zero !== 1'b0 || sat !== 1'b0) begin bad++; $display("FAIL reset_flags: got dz=%b sat=%b want 0 0", div_zero, sat); end
    endtask

    task automatic test_identity();
        int lat;
        run_op(16'sd2048, 16'sd0, 16'sd2048, 16'sd0, lat);
        total++; if (lat != 18) begin bad++; $display("FAIL identity_latency: got %0d want 18", lat); end
        total++; if (out_re !== 16'sd2048 || out_im !== 16'sd0) begin bad++; $display("FAIL identity_out: got (%0d,%0d) want (2048,0)", out_re, out_im); end
        total++; if (div_zero !== 1'b0 || sat !== 1'b0) begin bad++; $display("FAIL identity_flags: got dz=%b sat=%b want 0 0", div_zero, sat); end
        finish_op();
    endtask

    task automatic test_divide();
        // {ar, ai, br, bi, expected re, expected im}
        logic signed [15:0] vec [7][6] = '{
            '{16'sd2048,  16'sd2048,  16'sd0,    16'sd2048, 16'sd2048,  -16'sd2048},
            '{16'sd2048,  16'sd0,     16'sd6144, 16'sd0,    16'sd682,   16'sd0},
            '{-16'sd2048, 16'sd0,     16'sd6144, 16'sd0,    -16'sd682,  16'sd0},
            '{16'sd1024,  16'sd0,     16'sd2048, 16'sd2048, 16'sd512,   -16'sd512},
            '{16'sd0,     -16'sd2048, 16'sd6144, 16'sd0,    16'sd0,     -16'sd682},
            '{16'sd2048,  16'sd0,     16'sd0,    16'sd2048, 16'sd0,     -16'sd2048},
            '{-16'sd2048, -16'sd2048, 16'sd2048, 16'sd0,    -16'sd2048, -16'sd2048}
        };
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(vec[i][0], vec[i][1], vec[i][2], vec[i][3], lat);
            total++;
            if (lat != 18 || out_re !== vec[i][4] || out_im !== vec[i][5] || sat !== 1'b0 || div_zero !== 1'b0) begin
                bad++;
                $display("FAIL divide_vec%0d: got (%0d,%0d) lat=%0d sat=%b dz=%b want (%0d,%0d) lat=18 sat=0 dz=0",
                         i, out_re, out_im, lat, sat, div_zero, vec[i][4], vec[i][5]);
            end
            finish_op();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(16'sd1024, -16'sd512, 16'sd0, 16'sd0, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL divzero_latency: got %0d want 2", lat); end
        total++; if (out_re !== 16'sd0 || out_im !== 16'sd0) begin bad++; $display("FAIL divzero_out: got (%0d,%0d) want (0,0)", out_re, out_im); end
        total++; if (div_zero !== 1'b1 || sat !== 1'b0) begin bad++; $display("FAIL divzero_flags: got dz=%b sat=%b want 1 0", div_zero, sat); end
        finish_op();
    endtask

    task automatic test_saturation();
        int lat;
        run_op(16'sd16384, -16'sd16384, 16'sd64, 16'sd0, lat);
        total++; if (out_re !== 16'sd32767 || out_im !== -16'sd32768 || sat !== 1'b1) begin
            bad++; $display("FAIL sat_overflow: got (%0d,%0d) sat=%b want (32767,-32768) sat=1", out_re, out_im, sat); end
        finish_op();
        run_op(16'sd2048, 16'sd0, 16'sd2048, 16'sd0, lat);
        total++; if (out_re !== 16'sd2048 || sat !== 1'b0) begin
            bad++; $display("FAIL sat_clears: got re=%0d sat=%b want re=2048 sat=0", out_re, sat); end
        finish_op();
        // Magnitude exactly 2^15: representable when negative, saturates when positive.
        run_op(-16'sd32768, 16'sd0, 16'sd2048, 16'sd0, lat);
        total++; if (out_re !== -16'sd32768 || out_im !== 16'sd0 || sat !== 1'b0) begin
            bad++; $display("FAIL sat_neg_edge: got (%0d,%0d) sat=%b want (-32768,0) sat=0", out_re, out_im, sat); end
        finish_op();
        run_op(-16'sd32768, 16'sd0, -16'sd2048, 16'sd0, lat);
        total++; if (out_re !== 16'sd32767 || out_im !== 16'sd0 || sat !== 1'b1) begin
            bad++; $display("FAIL sat_pos_edge: got (%0d,%0d) sat=%b want (32767,0) sat=1", out_re, out_im, sat); end
        finish_op();
    endtask

    task automatic test_hold();
        int lat;
        run_op(16'sd2048, 16'sd2048, 16'sd0, 16'sd2048, lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_re !== 16'sd2048 || out_im !== -16'sd2048 || sat !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: got v=%b (%0d,%0d) sat=%b rdy=%b want v=1 (2048,-2048) sat=0 rdy=0",
                         i, out_valid, out_re, out_im, sat, in_ready);
            end
        end
        finish_op();
        total++; if (out_valid !== 1'b0 || out_re !== 16'sd2048 || out_im !== -16'sd2048) begin
            bad++; $display("FAIL hold_after_valid: got v=%b (%0d,%0d) want v=0 (2048,-2048)", out_valid, out_re, out_im); end
    endtask

    task automatic test_ignore();
        int lat;
        in_one_re = 16'sd2048; in_one_im = 16'sd0; in_two_re = 16'sd6144; in_two_im = 16'sd0;
        in_valid  = 1'b1;
        tick();
        // Keep In_Valid high with a divide-by-zero operand through CALC and DIV.
        in_one_re = 16'sd100; in_two_re = 16'sd0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL ignore_in_ready%0d: got %b want 0", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        lat = 6;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        total++; if (lat != 18 || out_re !== 16'sd682 || out_im !== 16'sd0 || div_zero !== 1'b0) begin
            bad++; $display("FAIL ignore_result: got (%0d,%0d) lat=%0d dz=%b want (682,0) lat=18 dz=0", out_re, out_im, lat, div_zero); end
        finish_op();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(16'sd2048, 16'sd0, 16'sd2048, 16'sd0, lat);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_done: got %b want 0", in_ready); end
        finish_op();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after: got %b want 1", in_ready); end
        run_op(16'sd1024, 16'sd0, 16'sd2048, 16'sd2048, lat);
        total++; if (lat != 18 || out_re !== 16'sd512 || out_im !== -16'sd512) begin
            bad++; $display("FAIL b2b_second: got (%0d,%0d) lat=%0d want (512,-512) lat=18", out_re, out_im, lat); end
        finish_op();
    endtask

    task automatic test_reset_mid();
        int lat;
        int spurious;
        // Outputs currently hold (512,-512) from the previous operation.
        in_one_re = 16'sd2048; in_one_im = 16'sd2048; in_two_re = 16'sd0; in_two_im = 16'sd2048;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        // Edge 1 enters DIV; DIV iteration 7 is taken at edge 9.
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_ctrl: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        total++; if (out_re !== 16'sd0 || out_im !== 16'sd0 || div_zero !== 1'b0 || sat !== 1'b0) begin
            bad++; $display("FAIL midreset_out: got (%0d,%0d) dz=%b sat=%b want (0,0) 0 0", out_re, out_im, div_zero, sat); end
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) spurious++;
            tick();
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL midreset_no_result: got %0d valid cycles want 0", spurious); end
        run_op(-16'sd2048, 16'sd0, 16'sd6144, 16'sd0, lat);
        total++; if (lat != 18 || out_re !== -16'sd682 || out_im !== 16'sd0) begin
            bad++; $display("FAIL midreset_next: got (%0d,%0d) lat=%0d want (-682,0) lat=18", out_re, out_im, lat); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_divide();
        test_div_zero();
        test_saturation();
        test_hold();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
